// File: rtl/paint_fb_writer.sv
// Paint framebuffer writer: cursor-driven pixel painter over a 2048 x 24-bit dual-port framebuffer.
// Optional macro PAINT_CURSOR_EN overlays a blinking inverted cursor on the panel read data.
module paint_fb_writer #(
    parameter int          BLINK_W     = 22,
    parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [11:0] cmd_color,
    input  logic [10:0] pix_addr,
    output logic [23:0] mem_rdata,
    output logic [5:0]  cursor_x,
    output logic [5:0]  cursor_y,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RD, WR, CLR} state_t;

    localparam logic [2:0] OP_UP        = 3'd1;
    localparam logic [2:0] OP_DOWN      = 3'd2;
    localparam logic [2:0] OP_LEFT      = 3'd3;
    localparam logic [2:0] OP_RIGHT     = 3'd4;
    localparam logic [2:0] OP_PAINT     = 3'd5;
    localparam logic [2:0] OP_SET_COLOR = 3'd6;
    localparam logic [2:0] OP_CLEAR     = 3'd7;

    if (BLINK_W < 2) begin : g_blink_w_check
        $error("BLINK_W must be at least 2");
    end

    state_t      state;
    state_t      state_next;
    logic [11:0] draw_color;
    logic [10:0] clr_addr;
    logic [23:0] fb [0:2047];
    logic [23:0] paint_word;
    logic [23:0] rdata_q;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [23:0] wr_data;
    logic        xfer;
    logic [10:0] cursor_addr;

    assign cursor_addr = {cursor_y[4:0], cursor_x};
    assign xfer        = cmd_valid & cmd_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Rows 32..63 live in the low half of the word, rows 0..31 in the high half.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = cursor_addr;
        wr_data    = cursor_y[5] ? {paint_word[23:12], draw_color}
                                 : {draw_color, paint_word[11:0]};
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    if (cmd_op == OP_PAINT) begin
                        state_next = RD;
                    end else if (cmd_op == OP_CLEAR) begin
                        state_next = CLR;
                    end
                end
            end
            RD: begin
                state_next = WR;
            end
            WR: begin
                wr_en      = 1'b1;
                state_next = IDLE;
            end
            CLR: begin
                wr_en   = 1'b1;
                wr_addr = clr_addr;
                wr_data = {CLEAR_COLOR, CLEAR_COLOR};
                if (clr_addr == 11'd2047) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cursor_x   <= 6'd0;
            cursor_y   <= 6'd0;
            draw_color <= 12'hFFF;
        end else if (xfer) begin
            case (cmd_op)
                OP_UP:        if (cursor_y != 6'd0)  cursor_y <= cursor_y - 6'd1;
                OP_DOWN:      if (cursor_y != 6'd63) cursor_y <= cursor_y + 6'd1;
                OP_LEFT:      if (cursor_x != 6'd0)  cursor_x <= cursor_x - 6'd1;
                OP_RIGHT:     if (cursor_x != 6'd63) cursor_x <= cursor_x + 6'd1;
                OP_SET_COLOR: draw_color <= cmd_color;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_addr <= 11'd0;
        end else if (state == CLR) begin
            clr_addr <= clr_addr + 11'd1;
        end
    end

    // Framebuffer storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (state == RD) begin
            paint_word <= fb[cursor_addr];
        end
        if (wr_en) begin
            fb[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= 24'h0;
        end else begin
            rdata_q <= fb[pix_addr];
        end
    end

`ifdef PAINT_CURSOR_EN
    logic [BLINK_W-1:0] blink;
    logic [10:0]        raddr_q;
    logic [23:0]        cursor_mask;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink   <= '0;
            raddr_q <= 11'd0;
        end else begin
            blink   <= blink + BLINK_W'(1);
            raddr_q <= pix_addr;
        end
    end

    always_comb begin
        cursor_mask = 24'h0;
        if ((raddr_q == cursor_addr) && blink[BLINK_W-1]) begin
            cursor_mask = cursor_y[5] ? 24'h000FFF : 24'hFFF000;
        end
    end

    assign mem_rdata = rdata_q ^ cursor_mask;
`else
    assign mem_rdata = rdata_q;
`endif

endmodule

// File: doc/paint_fb_writer.md
PAINT_FB_WRITER -- requirements
Module: paint_fb_writer

Interface
REQ-001 Parameter BLINK_W, default 22: width of the cursor blink counter; blink phase = counter MSB.
REQ-002 Parameter CLEAR_COLOR, default 12'h000: pixel value written by CLEAR.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  paint command present.
REQ-006 cmd_ready  output  1  block can accept a command this cycle.
REQ-007 cmd_op  input  3  0 NOP, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 PAINT, 6 SET_COLOR, 7 CLEAR.
REQ-008 cmd_color  input  12  {R[3:0],G[3:0],B[3:0]}; used only by SET_COLOR.
REQ-009 pix_addr  input  11  panel read address {row[4:0], col[5:0]}.
REQ-010 mem_rdata  output  24  panel read data: [23:12] pixel at (col,row), [11:0] pixel at (col,row+32).
REQ-011 cursor_x / cursor_y  output  6 each  current cursor column / row.
REQ-012 busy  output  1  high while a PAINT or CLEAR is in progress.

Function
REQ-013 Framebuffer: 2048 x 24-bit dual-port storage, one write port (internal), one read port (panel).
REQ-014 Read port: mem_rdata registered, valid one cycle after pix_addr is sampled; reads proceed every cycle regardless of FSM state.
REQ-015 Same-address read/write in one cycle returns the old word.
REQ-016 Handshake: command transfers when cmd_valid & cmd_ready; cmd_ready = 1 only in IDLE; cmd_op/cmd_color are sampled only on transfer.
REQ-017 FSM states IDLE, RD, WR, CLR.
REQ-018 IDLE: UP/DOWN/LEFT/RIGHT/SET_COLOR/NOP complete in the transfer cycle; state stays IDLE; cmd_ready stays 1.
REQ-019 Moves saturate: UP at y=0, DOWN at y=63, LEFT at x=0, RIGHT at x=63 leave the cursor unchanged.
REQ-020 SET_COLOR loads cmd_color into the draw-colour register on the clock edge ending the transfer cycle.
REQ-021 PAINT: IDLE->RD (read word {cursor_y[4:0],cursor_x})->WR (write merged word)->IDLE; cmd_ready low for exactly 2 cycles.
REQ-022 Merge in WR: cursor_y[5]=0 replaces [23:12], cursor_y[5]=1 replaces [11:0] with draw colour; other half preserved from RD data.
REQ-023 CLEAR: IDLE->CLR; writes {CLEAR_COLOR,CLEAR_COLOR} to addresses 0..2047 ascending, one per cycle; after 2047 -> IDLE; cmd_ready low for exactly 2048 cycles.
REQ-024 Cursor position and draw colour are unchanged by PAINT and CLEAR.
REQ-025 busy = 1 in RD, WR, CLR; 0 in IDLE.
REQ-026 Blink counter (BLINK_W bits) free-runs and wraps modulo 2^BLINK_W.

Reset
REQ-027 On rst low, asynchronously: state IDLE, cursor (0,0), draw colour 12'hFFF, clear address 0, blink counter 0, mem_rdata 24'h0.
REQ-028 cmd_ready reads 1 and busy reads 0 during reset.
REQ-029 Framebuffer contents are not reset; reset asserted mid-PAINT or mid-CLEAR aborts it with no further writes.

Configuration
REQ-030 Macro PAINT_CURSOR_EN defined: when the registered read address equals {cursor_y[4:0],cursor_x} and blink MSB=1, the half selected by cursor_y[5] is output bitwise inverted; the other half and storage are unaltered.
REQ-031 Macro PAINT_CURSOR_EN undefined: mem_rdata always equals stored data; blink counter is not implemented.

Verification
REQ-032 Reset, then RIGHT x3, DOWN x2 -> cursor_x=3, cursor_y=2, cmd_ready never drops.
REQ-033 LEFT and UP at (0,0); 70 RIGHT -> cursor stays (0,0), then cursor_x=63.
REQ-034 SET_COLOR 12'hF00, cursor (5,40), PAINT -> 2 cycles cmd_ready=0; read addr {5'd8,6'd5} -> [11:0]=12'hF00, [23:12] unchanged.
REQ-035 Paint (5,8) 12'h0F0 after REQ-034 -> word {5'd8,6'd5} = 24'h0F0F00.
REQ-036 CLEAR with CLEAR_COLOR=12'h000 -> cmd_ready low 2048 cycles, busy high, all addresses read 24'h0; rst pulsed at cycle 1000 of a second CLEAR -> cmd_ready=1 immediately.
REQ-037 With PAINT_CURSOR_EN, BLINK_W=4: cursor (0,0) over 24'h000000 -> [23:12] alternates 12'hFFF/12'h000 every 8 cycles.
